// File: rtl/jtag_bsr_driver.sv
// JTAG boundary-scan driver for the 4-bit FUNCTION FSM. It has a 16-state TAP, a 2-bit IR and an
// {Y,X} data register, and it drives X_out plus a one-cycle STEP qualifier into the FSM.
module jtag_bsr_driver #(
  parameter int X_W = 4,
  parameter int Y_W = 4
) (
  input  logic           TCK,
  input  logic           RESET,
  input  logic           TMS,
  input  logic           TDI,
  output logic           TDO,
  output logic           TDO_EN,
  input  logic [Y_W-1:0] Y_in,
  output logic [X_W-1:0] X_out,
  output logic           STEP,
  output logic [3:0]     TAP_STATE
);

  localparam int DR_W = X_W + Y_W;

  typedef enum logic [3:0] {
    S_TLR     = 4'hF,
    S_RTI     = 4'hC,
    S_SELDR   = 4'h7,
    S_CAPDR   = 4'h6,
    S_SHDR    = 4'h2,
    S_EX1DR   = 4'h1,
    S_PAUSEDR = 4'h3,
    S_EX2DR   = 4'h0,
    S_UPDDR   = 4'h5,
    S_SELIR   = 4'h4,
    S_CAPIR   = 4'hE,
    S_SHIR    = 4'hA,
    S_EX1IR   = 4'h9,
    S_PAUSEIR = 4'hB,
    S_EX2IR   = 4'h8,
    S_UPDIR   = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    I_EXTEST = 2'b00,
    I_SAMPLE = 2'b01,
    I_STEP   = 2'b10,
    I_BYPASS = 2'b11
  } instr_t;

  tap_state_t      r_state;
  instr_t          r_ir;
  logic [1:0]      r_ir_shift;
  logic [DR_W-1:0] r_dr;
  logic            r_bypass;
  logic [X_W-1:0]  r_x_out;
  logic            r_step;

  // The standard IEEE 1149.1 TMS graph.
  function automatic tap_state_t f_next_state(input tap_state_t state, input logic tms);
    case (state)
      S_TLR:     return tms ? S_TLR   : S_RTI;
      S_RTI:     return tms ? S_SELDR : S_RTI;
      S_SELDR:   return tms ? S_SELIR : S_CAPDR;
      S_CAPDR:   return tms ? S_EX1DR : S_SHDR;
      S_SHDR:    return tms ? S_EX1DR : S_SHDR;
      S_EX1DR:   return tms ? S_UPDDR : S_PAUSEDR;
      S_PAUSEDR: return tms ? S_EX2DR : S_PAUSEDR;
      S_EX2DR:   return tms ? S_UPDDR : S_SHDR;
      S_UPDDR:   return tms ? S_SELDR : S_RTI;
      S_SELIR:   return tms ? S_TLR   : S_CAPIR;
      S_CAPIR:   return tms ? S_EX1IR : S_SHIR;
      S_SHIR:    return tms ? S_EX1IR : S_SHIR;
      S_EX1IR:   return tms ? S_UPDIR : S_PAUSEIR;
      S_PAUSEIR: return tms ? S_EX2IR : S_PAUSEIR;
      S_EX2IR:   return tms ? S_UPDIR : S_SHIR;
      S_UPDIR:   return tms ? S_SELDR : S_RTI;
      default:   return S_TLR;
    endcase
  endfunction

  // NOTE: every register is written with <= so that all of them see the pre-edge values of
  // r_state/r_ir/r_dr. A blocking write here would let later statements see the new values.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      r_state    <= S_TLR;
      r_ir       <= I_BYPASS;
      r_ir_shift <= 2'b00;
      r_dr       <= '0;
      r_bypass   <= 1'b0;
      r_x_out    <= '0;
      r_step     <= 1'b0;
    end else begin
      r_state <= f_next_state(r_state, TMS);
      // UpdDR always lasts exactly one cycle, so this gives one pulse per visit.
      r_step  <= (r_state == S_UPDDR) && (r_ir == I_STEP);
      case (r_state)
        S_TLR: begin
          r_ir    <= I_BYPASS;
          r_x_out <= '0;
        end
        S_CAPIR: r_ir_shift <= 2'b01;
        S_SHIR:  r_ir_shift <= {TDI, r_ir_shift[1]};
        S_UPDIR: r_ir       <= instr_t'(r_ir_shift);
        S_CAPDR: begin
          if (r_ir == I_BYPASS) r_bypass <= 1'b0;
          else                  r_dr     <= {Y_in, r_x_out};
        end
        S_SHDR: begin
          if (r_ir == I_BYPASS) r_bypass <= TDI;
          else                  r_dr     <= {TDI, r_dr[DR_W-1:1]};
        end
        S_UPDDR: begin
          if (r_ir == I_EXTEST || r_ir == I_STEP) r_x_out <= r_dr[X_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: TDO gets a default value first, so every path assigns it and no latch is inferred.
  always_comb begin
    TDO = 1'b0;
    if (r_state == S_SHIR)      TDO = r_ir_shift[0];
    else if (r_state == S_SHDR) TDO = (r_ir == I_BYPASS) ? r_bypass : r_dr[0];
  end

  assign TDO_EN    = (r_state == S_SHIR) || (r_state == S_SHDR);
  assign X_out     = r_x_out;
  assign STEP      = r_step;
  assign TAP_STATE = r_state;

endmodule

// File: doc/jtag_bsr_driver.md
Name: jtag_bsr_driver

Overview:
- JTAG-side driver for the 4-bit FUNCTION FSM block.
- Contains a standard 16-state TAP controller, a 2-bit instruction register and an 8-bit boundary data register.
- Serially loads a stimulus vector from TDI and drives it onto the FSM's X_in. Captures the FSM's Y_out and shifts it out on TDO.
- Issues a one-cycle STEP qualifier so a test host can advance the FSM one transition at a time.

Parameters:
X_W, 4, width of stimulus vector driven to the FSM X_in
Y_W, 4, width of response vector captured from the FSM Y_out

Ports:
TCK  input  1  single clock; all logic on rising edge
RESET  input  1  synchronous reset, active-high (sampled on rising TCK)
TMS  input  1  test mode select, sampled on rising TCK
TDI  input  1  serial data in, sampled on rising TCK
TDO  output  1  serial data out (combinational from state/registers)
TDO_EN  output  1  high while in Shift-IR or Shift-DR
Y_in  input  Y_W  response from FSM Y_out
X_out  output  X_W  stimulus to FSM X_in (registered)
STEP  output  1  one-cycle pulse: FSM may advance this cycle
TAP_STATE  output  4  current TAP state code

Behaviour:
- State codes (IEEE 1149.1):
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions follow the standard TMS graph. Five consecutive TMS=1 cycles reach TLR from any state.
- RESET (has priority over everything):
  - TAP_STATE=F, IR=BYPASS, ir_shift=00, dr=0, bypass=0
  - X_out=0, STEP=0
  - TDO=0, TDO_EN=0
- Instructions (2-bit): EXTEST=00, SAMPLE=01, STEP=10, BYPASS=11. All codes are defined.
- While in TLR: IR<=BYPASS and X_out<=0 every cycle.
- IR path:
  - CapIR: ir_shift<=2'b01.
  - ShIR: ir_shift<={TDI, ir_shift[1]}; TDO=ir_shift[0].
  - UpdIR: IR<=ir_shift.
- DR select: BYPASS selects the 1-bit bypass register. All other instructions select dr[X_W+Y_W-1:0] = {Y field, X field}.
- CapDR:
  - BYPASS: bypass<=0.
  - Otherwise: dr<={Y_in, X_out}.
- ShDR:
  - BYPASS: bypass<=TDI; TDO=bypass.
  - Otherwise: dr<={TDI, dr[MSB:1]}; TDO=dr[0]. Shifting is LSB-first out, MSB-first in.
- UpdDR:
  - EXTEST or STEP: X_out<=dr[X_W-1:0].
  - SAMPLE or BYPASS: X_out unchanged.
- STEP output:
  - Registered; high for exactly one cycle, on the edge that leaves UpdDR while IR=STEP. This holds regardless of the next state (RTI or SelDR).
  - X_out takes its new value on the same edge, so the FSM sees the new X while STEP=1.
  - Back-to-back UpdDR visits give one pulse each. STEP is never high in any other situation.
- Pause/Exit states: dr, ir_shift and X_out all hold.
- TDO is 0 and TDO_EN is 0 outside the ShIR and ShDR states.
- Latency:
  - TDI to X_out: n shift cycles + Ex1DR + UpdDR, with X_out valid on the edge leaving UpdDR.
  - Y_in is sampled exactly on the edge leaving CapDR.
- Reset mid-operation: any partial shift is discarded. No X_out update and no STEP pulse result.
- RESET and UpdDR in the same cycle: reset wins, X_out=0, STEP=0.

Test Plan:
1. RESET for 1 cycle, then TMS=1 x5 -> TAP_STATE=F, X_out=0000, STEP=0; a 2-bit DR shift with TDI=1 gives TDO sequence 0,1 (bypass).
2. IR shift of 00 (EXTEST) -> TDO emits 1,0 during ShIR; then 8-bit DR shift with X field 1010 -> X_out=1010 after UpdDR; STEP stays 0 throughout.
3. IR=STEP, Y_in=0110, DR shift with X field 0010 -> TDO first 8 bits 0,1,0,1,0,1,1,0 (prior X=1010, Y=0110 LSB-first); X_out=0010 and STEP=1 for exactly one cycle on leaving UpdDR; a second UpdDR gives a second single pulse.
4. IR=SAMPLE, X_out=1010, Y_in=1101 -> TDO 0,1,0,1,1,0,1,1; X_out remains 1010 after UpdDR; STEP=0.
5. RESET asserted after 3 ShDR cycles under EXTEST -> next cycle TAP_STATE=F, X_out=0000, TDO_EN=0, no STEP pulse.
6. From PauseDR, TMS=1 x5 with no RESET -> TAP_STATE=F, IR reads back BYPASS, X_out=0000.
